// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if
// Bundles the controller's time-base and request inputs and its lamp and
// countdown outputs into one port.
//
// Signal semantics: there is no valid/ready handshake on this interface.
// tick is a one-cycle strobe that is acted on at the rising edge where it
// is sampled high. hold and night are levels. ped_req is a pulse that the
// controller latches. All outputs are combinational decodes of registered
// state and change only right after a rising clock edge.
//
// Signals:
//   tick, hold, night, ped_req    : driven by the system (master)
//   light_ew_rgyl, light_sn_rgyl  : lamp vectors {red, green, yellow, left}
//   cnt_ew, cnt_sn                : seconds until that road's lamp changes
//   ped_pending                   : pedestrian request latch
//   phase_dbg                     : current phase encoding, for observation
interface traffic_phase_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             tick;
    logic             hold;
    logic             night;
    logic             ped_req;
    logic [3:0]       light_ew_rgyl;
    logic [3:0]       light_sn_rgyl;
    logic [CNT_W-1:0] cnt_ew;
    logic [CNT_W-1:0] cnt_sn;
    logic             ped_pending;
    logic [3:0]       phase_dbg;

    modport master (
        output tick, hold, night, ped_req,
        input  light_ew_rgyl, light_sn_rgyl, cnt_ew, cnt_sn, ped_pending,
               phase_dbg
    );

    modport slave (
        input  tick, hold, night, ped_req,
        output light_ew_rgyl, light_sn_rgyl, cnt_ew, cnt_sn, ped_pending,
               phase_dbg
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Two-road intersection controller. A single phase register and a single
// remaining-ticks register drive both roads, so EW and SN can never drift.
// Adds pedestrian green truncation, flashing-yellow night mode and hold.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : traffic_phase_ctrl_if slave (tick/hold/night/ped_req in;
//           lamps, countdowns, ped_pending, phase_dbg out)
module traffic_phase_ctrl #(
    parameter int CNT_W   = 8,
    parameter int G_EW    = 40,
    parameter int L_EW    = 15,
    parameter int G_SN    = 30,
    parameter int L_SN    = 15,
    parameter int Y_T     = 5,
    parameter int PED_MIN = 5
) (
    input logic                  clk,
    input logic                  reset,
    traffic_phase_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        EW_G  = 4'd0,
        EW_Y1 = 4'd1,
        EW_L  = 4'd2,
        EW_Y2 = 4'd3,
        SN_G  = 4'd4,
        SN_Y1 = 4'd5,
        SN_L  = 4'd6,
        SN_Y2 = 4'd7,
        NIGHT = 4'd8
    } phase_t;

    localparam logic [CNT_W-1:0] D_GEW = CNT_W'(G_EW);
    localparam logic [CNT_W-1:0] D_LEW = CNT_W'(L_EW);
    localparam logic [CNT_W-1:0] D_GSN = CNT_W'(G_SN);
    localparam logic [CNT_W-1:0] D_LSN = CNT_W'(L_SN);
    localparam logic [CNT_W-1:0] D_Y   = CNT_W'(Y_T);
    localparam logic [CNT_W-1:0] D_PED = CNT_W'(PED_MIN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    localparam logic [3:0] LAMP_RED    = 4'b1000;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_LEFT   = 4'b0001;
    localparam logic [3:0] LAMP_OFF    = 4'b0000;

    phase_t           phase, phase_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             flash, flash_n;
    logic             ped, ped_n;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            EW_G:    next_phase = EW_Y1;
            EW_Y1:   next_phase = EW_L;
            EW_L:    next_phase = EW_Y2;
            EW_Y2:   next_phase = SN_G;
            SN_G:    next_phase = SN_Y1;
            SN_Y1:   next_phase = SN_L;
            SN_L:    next_phase = SN_Y2;
            default: next_phase = EW_G;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] phase_dur(input phase_t p);
        case (p)
            EW_G:    phase_dur = D_GEW;
            EW_L:    phase_dur = D_LEW;
            SN_G:    phase_dur = D_GSN;
            SN_L:    phase_dur = D_LSN;
            default: phase_dur = D_Y;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= EW_G;
            rem   <= D_GEW;
            flash <= 1'b0;
            ped   <= 1'b0;
        end else begin
            phase <= phase_n;
            rem   <= rem_n;
            flash <= flash_n;
            ped   <= ped_n;
        end
    end

    always_comb begin
        phase_n = phase;
        rem_n   = rem;
        flash_n = flash;
        ped_n   = ped;
        if (bus.night) begin
            // Night overrides hold and tick; requests are discarded.
            ped_n = 1'b0;
            if (phase != NIGHT) begin
                phase_n = NIGHT;
                flash_n = 1'b0;
            end else if (!bus.hold && bus.tick) begin
                flash_n = ~flash;
            end
        end else if (phase == NIGHT) begin
            phase_n = EW_G;
            rem_n   = D_GEW;
            flash_n = 1'b0;
            ped_n   = 1'b0;
        end else begin
            if (!bus.hold && bus.tick) begin
                if (rem == ONE) begin
                    phase_n = next_phase(phase);
                    rem_n   = phase_dur(next_phase(phase));
                    if (next_phase(phase) == EW_Y1 || next_phase(phase) == SN_Y1)
                        ped_n = 1'b0;
                end else if ((phase == EW_G || phase == SN_G) && ped && rem > D_PED) begin
                    // Truncation uses the registered latch, so a request
                    // sampled on this same edge only acts on the next tick.
                    rem_n = D_PED;
                end else begin
                    rem_n = rem - ONE;
                end
            end
            // A new request wins over the Y1-entry clear so none is lost.
            if (bus.ped_req)
                ped_n = 1'b1;
        end
    end

    // Output decode: the inactive road counts through the active road's
    // remaining phases, so it always shows time to its own next change.
    always_comb begin
        bus.light_ew_rgyl = LAMP_RED;
        bus.light_sn_rgyl = LAMP_RED;
        bus.cnt_ew        = rem;
        bus.cnt_sn        = rem;
        case (phase)
            EW_G: begin
                bus.light_ew_rgyl = LAMP_GREEN;
                bus.cnt_sn        = rem + D_Y + D_LEW + D_Y;
            end
            EW_Y1: begin
                bus.light_ew_rgyl = LAMP_YELLOW;
                bus.cnt_sn        = rem + D_LEW + D_Y;
            end
            EW_L: begin
                bus.light_ew_rgyl = LAMP_LEFT;
                bus.cnt_sn        = rem + D_Y;
            end
            EW_Y2: begin
                bus.light_ew_rgyl = LAMP_YELLOW;
            end
            SN_G: begin
                bus.light_sn_rgyl = LAMP_GREEN;
                bus.cnt_ew        = rem + D_Y + D_LSN + D_Y;
            end
            SN_Y1: begin
                bus.light_sn_rgyl = LAMP_YELLOW;
                bus.cnt_ew        = rem + D_LSN + D_Y;
            end
            SN_L: begin
                bus.light_sn_rgyl = LAMP_LEFT;
                bus.cnt_ew        = rem + D_Y;
            end
            SN_Y2: begin
                bus.light_sn_rgyl = LAMP_YELLOW;
            end
            default: begin
                bus.light_ew_rgyl = flash ? LAMP_OFF : LAMP_YELLOW;
                bus.light_sn_rgyl = flash ? LAMP_OFF : LAMP_YELLOW;
                bus.cnt_ew        = '0;
                bus.cnt_sn        = '0;
            end
        endcase
    end

    assign bus.ped_pending = ped;
    assign bus.phase_dbg   = phase;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    traffic_phase_ctrl_if #(.CNT_W(8)) bus ();

    traffic_phase_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       r, t, h, n, p;
        logic [3:0] ew, sn;
        logic [7:0] ce, cs;
        logic       ped;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [3:0] ew, input logic [3:0] sn,
                         input logic [7:0] ce, input logic [7:0] cs, input logic ped);
        n_cmp++;
        if (bus.light_ew_rgyl !== ew || bus.light_sn_rgyl !== sn ||
            bus.cnt_ew !== ce || bus.cnt_sn !== cs || bus.ped_pending !== ped) begin
            n_bad++;
            $display("FAIL %s: got ew=%b sn=%b cnt_ew=%0d cnt_sn=%0d ped=%b, want ew=%b sn=%b cnt_ew=%0d cnt_sn=%0d ped=%b",
                     name, bus.light_ew_rgyl, bus.light_sn_rgyl, bus.cnt_ew, bus.cnt_sn,
                     bus.ped_pending, ew, sn, ce, cs, ped);
        end
    endtask

    // One clock with the given inputs, then inputs return to idle and the
    // outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic t, input logic h,
                        input logic n, input logic p);
        reset       = r;
        bus.tick    = t;
        bus.hold    = h;
        bus.night   = n;
        bus.ped_req = p;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.tick    = 1'b0;
        bus.hold    = 1'b0;
        bus.ped_req = 1'b0;
    endtask

    // k ticks, each followed by 0..3 idle or hold+tick cycles.
    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            int gap;
            step(1'b0, 1'b1, 1'b0, bus.night, 1'b0);
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 1'b1, bus.night, 1'b0);
                else                           step(1'b0, 1'b0, 1'b0, bus.night, 1'b0);
            end
        end
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.hold    = 1'b0;
        bus.night   = 1'b0;
        bus.ped_req = 1'b0;

        //            r  t  h  n  p   ew       sn       ce  cs  ped
        tbl[0]  = '{1, 0, 0, 0, 0, 4'b0100, 4'b1000, 40, 65, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000, 39, 64, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 4'b0100, 4'b1000, 39, 64, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 4'b0100, 4'b1000, 39, 64, 0};
        tbl[4]  = '{0, 1, 0, 0, 1, 4'b0100, 4'b1000, 38, 63, 1};
        tbl[5]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000,  5, 30, 1};
        tbl[6]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000,  4, 29, 1};
        tbl[7]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000,  3, 28, 1};
        tbl[8]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000,  2, 27, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000,  1, 26, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 4'b0010, 4'b1000,  5, 25, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 4'b0010, 4'b0010,  0,  0, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 4'b0000, 4'b0000,  0,  0, 0};
        tbl[13] = '{0, 1, 1, 1, 0, 4'b0000, 4'b0000,  0,  0, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 4'b0000, 4'b0000,  0,  0, 0};
        tbl[15] = '{0, 1, 0, 1, 0, 4'b0010, 4'b0010,  0,  0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 4'b0100, 4'b1000, 40, 65, 0};
        tbl[17] = '{0, 0, 0, 0, 1, 4'b0100, 4'b1000, 40, 65, 1};
        tbl[18] = '{1, 0, 0, 0, 0, 4'b0100, 4'b1000, 40, 65, 0};
        tbl[19] = '{0, 1, 0, 0, 0, 4'b0100, 4'b1000, 39, 64, 0};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].h, tbl[i].n, tbl[i].p);
            check($sformatf("vec%0d", i), tbl[i].ew, tbl[i].sn, tbl[i].ce, tbl[i].cs, tbl[i].ped);
        end

        // First green boundary: 39 ticks to rem=1, 40th tick enters EW_Y1.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_values", 4'b0100, 4'b1000, 8'd40, 8'd65, 1'b0);
        ticks(39);
        check("ew_g_rem1", 4'b0100, 4'b1000, 8'd1, 8'd26, 1'b0);
        ticks(1);
        check("ew_y1_entry", 4'b0010, 4'b1000, 8'd5, 8'd25, 1'b0);

        // Full ring with gaps and held ticks.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(60);
        check("ring_ew_y2", 4'b0010, 4'b1000, 8'd5, 8'd5, 1'b0);
        ticks(5);
        check("ring_sn_g", 4'b1000, 4'b0100, 8'd55, 8'd30, 1'b0);
        ticks(55);
        check("ring_wrap", 4'b0100, 4'b1000, 8'd40, 8'd65, 1'b0);

        // Pedestrian truncation at rem=30.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ped_latched", 4'b0100, 4'b1000, 8'd30, 8'd55, 1'b1);
        ticks(1);
        check("ped_truncate", 4'b0100, 4'b1000, 8'd5, 8'd30, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(4);
        check("ped_no_extend", 4'b0100, 4'b1000, 8'd1, 8'd26, 1'b1);
        ticks(1);
        check("ped_clear_y1", 4'b0010, 4'b1000, 8'd5, 8'd25, 1'b0);

        // Late request at rem=3 does not truncate.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(37);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check("ped_late", 4'b0100, 4'b1000, 8'd2, 8'd27, 1'b1);

        // Night entered from SN_L.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(100);
        check("sn_l", 4'b1000, 4'b0001, 8'd20, 8'd15, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("night_entry", 4'b0010, 4'b0010, 8'd0, 8'd0, 1'b0);
        ticks(1);
        check("night_flash_off", 4'b0000, 4'b0000, 8'd0, 8'd0, 1'b0);
        ticks(1);
        check("night_flash_on", 4'b0010, 4'b0010, 8'd0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("night_exit", 4'b0100, 4'b1000, 8'd40, 8'd65, 1'b0);

        // Reset in SN_Y2 with tick and ped_req on the same edge.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(115);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sn_y2", 4'b1000, 4'b0010, 8'd5, 8'd5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_in_sn_y2", 4'b0100, 4'b1000, 8'd40, 8'd65, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
